// File: rtl/mispredict_recovery_controller.sv
// mispredict_recovery_controller
//
// Sequences pipeline recovery after a branch/JALR misprediction from one of
// three execute-stage functional units. Each cycle, the oldest mispredicting
// FU relative to the ROB head is chosen as the candidate. The controller then
// holds a flush window of FLUSH_CYCLES cycles and hands the redirect PC to
// fetch through a valid/ready handshake. A strictly older misprediction
// arriving while a recovery is pending replaces it and restarts the flush.
//
// Optional feature macro: RECOVERY_STATS_EN
//   defined   -> stat_recoveries / stat_overrides are 32-bit wrapping counters
//   undefined -> both stat ports are tied to zero
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   misprediction_0/1/2           FU x resolved a misprediction this cycle
//   correct_pc_0/1/2              redirect target from FU x
//   rob_idx_0/1/2                 ROB index of the instruction in FU x
//   rob_head                      current oldest ROB entry
//   flush_valid, flush_rob_idx    squash everything younger than flush_rob_idx
//   redirect_valid, redirect_pc   redirect request to fetch (pc word aligned)
//   redirect_ready                fetch accepts the redirect
//   recovery_busy                 recovery in progress; stalls dispatch
//   stat_recoveries               completed redirects
//   stat_overrides                pending recoveries replaced by an older one
module mispredict_recovery_controller #(
  parameter int DATA_WIDTH    = 32,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int FLUSH_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     misprediction_0,
  input  logic                     misprediction_1,
  input  logic                     misprediction_2,
  input  logic [DATA_WIDTH-1:0]    correct_pc_0,
  input  logic [DATA_WIDTH-1:0]    correct_pc_1,
  input  logic [DATA_WIDTH-1:0]    correct_pc_2,
  input  logic [ROB_IDX_WIDTH-1:0] rob_idx_0,
  input  logic [ROB_IDX_WIDTH-1:0] rob_idx_1,
  input  logic [ROB_IDX_WIDTH-1:0] rob_idx_2,
  input  logic [ROB_IDX_WIDTH-1:0] rob_head,
  output logic                     flush_valid,
  output logic [ROB_IDX_WIDTH-1:0] flush_rob_idx,
  output logic                     redirect_valid,
  output logic [DATA_WIDTH-1:0]    redirect_pc,
  input  logic                     redirect_ready,
  output logic                     recovery_busy,
  output logic [31:0]              stat_recoveries,
  output logic [31:0]              stat_overrides
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [3:0]            FLUSH_LOAD    = 4'(FLUSH_CYCLES);
  localparam logic [DATA_WIDTH-1:0] PC_ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  state_t                   state, next_state;
  logic [ROB_IDX_WIDTH-1:0] stored_idx, next_idx;
  logic [DATA_WIDTH-1:0]    stored_pc, next_pc;
  logic [3:0]               cnt, next_cnt;

  // Candidate selection: ages are distances from the ROB head, so the
  // modulo subtraction handles pointer wrap. Strict '<' keeps the lower FU
  // index on equal ages.
  logic [ROB_IDX_WIDTH-1:0] age_0, age_1, age_2;
  logic [ROB_IDX_WIDTH-1:0] cand_age, cand_idx, stored_age;
  logic [DATA_WIDTH-1:0]    cand_pc;
  logic                     cand_valid;
  logic                     cand_older;

  always_comb begin
    age_0      = rob_idx_0 - rob_head;
    age_1      = rob_idx_1 - rob_head;
    age_2      = rob_idx_2 - rob_head;
    cand_valid = misprediction_0;
    cand_idx   = rob_idx_0;
    cand_pc    = correct_pc_0;
    cand_age   = age_0;
    if (misprediction_1 && (!cand_valid || (age_1 < cand_age))) begin
      cand_valid = 1'b1;
      cand_idx   = rob_idx_1;
      cand_pc    = correct_pc_1;
      cand_age   = age_1;
    end
    if (misprediction_2 && (!cand_valid || (age_2 < cand_age))) begin
      cand_valid = 1'b1;
      cand_idx   = rob_idx_2;
      cand_pc    = correct_pc_2;
      cand_age   = age_2;
    end
    // Pending entry's age moves with the head, so recompute every cycle.
    stored_age = stored_idx - rob_head;
    cand_older = cand_valid && (cand_age < stored_age);
  end

  always_comb begin
    next_state = state;
    next_idx   = stored_idx;
    next_pc    = stored_pc;
    next_cnt   = cnt;
    unique case (state)
      IDLE: begin
        if (cand_valid) begin
          next_state = FLUSH;
          next_idx   = cand_idx;
          next_pc    = cand_pc;
          next_cnt   = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (cand_older) begin
          next_idx = cand_idx;
          next_pc  = cand_pc;
          next_cnt = FLUSH_LOAD;
        end else if (cnt == 4'd1) begin
          next_state = REDIRECT;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      REDIRECT: begin
        // An older override beats a same-cycle handshake; any other
        // candidate in the handshake cycle starts a fresh recovery directly.
        if (cand_older) begin
          next_state = FLUSH;
          next_idx   = cand_idx;
          next_pc    = cand_pc;
          next_cnt   = FLUSH_LOAD;
        end else if (redirect_ready) begin
          if (cand_valid) begin
            next_state = FLUSH;
            next_idx   = cand_idx;
            next_pc    = cand_pc;
            next_cnt   = FLUSH_LOAD;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      stored_idx     <= '0;
      stored_pc      <= '0;
      cnt            <= '0;
      flush_valid    <= 1'b0;
      flush_rob_idx  <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      recovery_busy  <= 1'b0;
    end else begin
      state          <= next_state;
      stored_idx     <= next_idx;
      stored_pc      <= next_pc;
      cnt            <= next_cnt;
      flush_valid    <= (next_state == FLUSH);
      flush_rob_idx  <= next_idx;
      redirect_valid <= (next_state == REDIRECT);
      redirect_pc    <= next_pc & PC_ALIGN_MASK;
      recovery_busy  <= (next_state != IDLE);
    end
  end

`ifdef RECOVERY_STATS_EN
  logic [31:0] recov_q, ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      recov_q <= '0;
      ovr_q   <= '0;
    end else if ((state != IDLE) && cand_older) begin
      ovr_q <= ovr_q + 32'd1;
    end else if ((state == REDIRECT) && redirect_ready) begin
      recov_q <= recov_q + 32'd1;
    end
  end

  assign stat_recoveries = recov_q;
  assign stat_overrides  = ovr_q;
`else
  assign stat_recoveries = '0;
  assign stat_overrides  = '0;
`endif

endmodule

// File: tb/tb_mispredict_recovery_controller.sv
// Testbench for mispredict_recovery_controller: directed scenarios plus
// randomized traffic, checked each cycle against a behavioural model that
// tracks the pending recovery as (entry, flush cycles left).
module tb_mispredict_recovery_controller;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int FC = 2;
  localparam int ROB_DEPTH = 1 << RW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    mis = '0;
  logic [DW-1:0] cpc [3];
  logic [RW-1:0] ridx [3];
  logic [RW-1:0] rob_head = '0;
  logic          redirect_ready = 1'b0;

  logic          flush_valid, redirect_valid, recovery_busy;
  logic [RW-1:0] flush_rob_idx;
  logic [DW-1:0] redirect_pc;
  logic [31:0]   stat_recoveries, stat_overrides;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_have, m_left, m_idx, m_rec, m_ovr;
  logic [31:0] m_pc;

  mispredict_recovery_controller #(
    .DATA_WIDTH   (DW),
    .ROB_IDX_WIDTH(RW),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .misprediction_0(mis[0]),
    .misprediction_1(mis[1]),
    .misprediction_2(mis[2]),
    .correct_pc_0   (cpc[0]),
    .correct_pc_1   (cpc[1]),
    .correct_pc_2   (cpc[2]),
    .rob_idx_0      (ridx[0]),
    .rob_idx_1      (ridx[1]),
    .rob_idx_2      (ridx[2]),
    .rob_head       (rob_head),
    .flush_valid    (flush_valid),
    .flush_rob_idx  (flush_rob_idx),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .recovery_busy  (recovery_busy),
    .stat_recoveries(stat_recoveries),
    .stat_overrides (stat_overrides)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int age_of(input int idx);
    return (idx - int'(rob_head) + ROB_DEPTH) % ROB_DEPTH;
  endfunction

  task automatic model_reset();
    m_have = 0; m_left = 0; m_idx = 0; m_pc = '0; m_rec = 0; m_ovr = 0;
  endtask

  task automatic model_take(input int fu);
    m_have = 1;
    m_idx  = int'(ridx[fu]);
    m_pc   = cpc[fu];
    m_left = FC;
  endtask

  // One clock edge of the recovery rules.
  task automatic model_edge();
    int best;
    best = -1;
    for (int i = 0; i < 3; i++)
      if (mis[i] && (best < 0 || age_of(int'(ridx[i])) < age_of(int'(ridx[best]))))
        best = i;
    if (m_have == 0) begin
      if (best >= 0) model_take(best);
    end else if (best >= 0 && age_of(int'(ridx[best])) < age_of(m_idx)) begin
      model_take(best);
      m_ovr++;
    end else if (m_left > 0) begin
      m_left--;
    end else if (redirect_ready) begin
      m_rec++;
      if (best >= 0) model_take(best);
      else m_have = 0;
    end
  endtask

  task automatic check_outputs();
    logic exp_flush, exp_redir;
    exp_flush = (m_have != 0) && (m_left > 0);
    exp_redir = (m_have != 0) && (m_left == 0);
    check("flush_valid", flush_valid, exp_flush);
    if (exp_flush) check("flush_rob_idx", flush_rob_idx, m_idx);
    check("redirect_valid", redirect_valid, exp_redir);
    if (exp_redir) check("redirect_pc", redirect_pc, m_pc & 32'hFFFF_FFFC);
    check("recovery_busy", recovery_busy, m_have != 0);
`ifdef RECOVERY_STATS_EN
    check("stat_recoveries", stat_recoveries, m_rec);
    check("stat_overrides", stat_overrides, m_ovr);
`else
    check("stat_recoveries", stat_recoveries, 0);
    check("stat_overrides", stat_overrides, 0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic set_fu(input int fu, input logic [RW-1:0] idx, input logic [DW-1:0] pc);
    mis[fu]  = 1'b1;
    ridx[fu] = idx;
    cpc[fu]  = pc;
  endtask

  task automatic drain();
    mis = '0;
    redirect_ready = 1'b1;
    for (int i = 0; i < 40 && m_have != 0; i++) step();
    check("drain_idle", recovery_busy, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] held_pc;
    for (int i = 0; i < 3; i++) begin cpc[i] = '0; ridx[i] = '0; end
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_flush_valid", flush_valid, 1'b0);
    check("rst_flush_idx", flush_rob_idx, 0);
    check("rst_redirect_valid", redirect_valid, 1'b0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_busy", recovery_busy, 1'b0);
    check("rst_stat_rec", stat_recoveries, 0);
    check("rst_stat_ovr", stat_overrides, 0);
    rst = 1'b0;
    step();

    // Single mispredict, redirect accepted immediately
    rob_head = 5'd0; redirect_ready = 1'b1;
    set_fu(1, 5'd7, 32'h0000_1236);
    step();                         // N+1
    mis = '0;
    check("single_flush_n1", flush_valid, 1'b1);
    check("single_idx", flush_rob_idx, 7);
    step();                         // N+2
    check("single_flush_n2", flush_valid, 1'b1);
    step();                         // N+3
    check("single_redir", redirect_valid, 1'b1);
    check("single_pc", redirect_pc, 32'h0000_1234);
    step();                         // N+4
    check("single_idle", recovery_busy, 1'b0);

    // Simultaneous mispredicts across the ROB wrap
    rob_head = 5'd30;
    set_fu(0, 5'd2, 32'h0000_A000);
    set_fu(1, 5'd31, 32'h0000_B000);
    set_fu(2, 5'd5, 32'h0000_C000);
    step();
    mis = '0;
    check("wrap_idx", flush_rob_idx, 31);
    drain();

    // Override during FLUSH, then a younger mispredict is ignored
    rob_head = 5'd0;
    set_fu(0, 5'd10, 32'h0000_2000);
    step();
    mis = '0;
    set_fu(2, 5'd4, 32'h0000_3000);
    step();
    mis = '0;
    check("ovr_flush_idx", flush_rob_idx, 4);
    set_fu(1, 5'd12, 32'h0000_4000);
    step();
    mis = '0;
    check("ovr_ignore_idx", flush_rob_idx, 4);
    drain();

    // Ready backpressure
    redirect_ready = 1'b0;
    set_fu(0, 5'd9, 32'h0000_5557);
    step();
    mis = '0;
    step(); step();
    held_pc = redirect_pc;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_valid", redirect_valid, 1'b1);
      check("bp_pc_stable", redirect_pc, held_pc);
    end
    redirect_ready = 1'b1;
    step();
    check("bp_idle", recovery_busy, 1'b0);

    // Override in REDIRECT wins over a same-cycle handshake
    redirect_ready = 1'b0;
    set_fu(1, 5'd20, 32'h0000_6000);
    step(); mis = '0; step(); step();
    check("rdovr_pre", redirect_valid, 1'b1);
    set_fu(0, 5'd3, 32'h0000_7004);
    redirect_ready = 1'b1;
    step();
    mis = '0;
    check("rdovr_dropped", redirect_valid, 1'b0);
    check("rdovr_flush_idx", flush_rob_idx, 3);
    drain();

    // Asynchronous reset mid-FLUSH
    set_fu(2, 5'd15, 32'h0000_8000);
    step();
    mis = '0;
    #2 rst = 1'b1;
    #1;
    check("arst_flush", flush_valid, 1'b0);
    check("arst_busy", recovery_busy, 1'b0);
    rst = 1'b0;
    model_reset();
    redirect_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 3; i++) begin
        mis[i]  = ($urandom_range(0, 5) == 0);
        ridx[i] = RW'($urandom);
        cpc[i]  = $urandom;
      end
      if ($urandom_range(0, 3) == 0) rob_head = rob_head + RW'($urandom_range(0, 2));
      redirect_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
